th_imem_responder: RTL and testbench
====================================

// Module: th_imem_responder
// PURPOSE
//   Responder (memory side) of the TTA core's instruction-fetch bus (i_read/i_rack/i_ready/i_addr/i_data).
//   Serves fetches from an internal synchronous-read block RAM with a parameterised number of wait states.
//   A loader write port fills the program store.
//   Sits between th_top's fetch port and on-chip program memory; replaces bench-level BRAM glue.
// PARAMETERS
//   WIDTH        18   core data width (address formation only)
//   PAGEWIDTH    10   page-field width; ADDRESS = WIDTH + PAGEWIDTH = 28
//   INSTRUCTION  32   instruction word width
//   DEPTHBITS    9    log2 of program-store words (512)
//   WAIT         0    extra wait states per fetch, 0..15
//   NOP          0    instruction word returned for out-of-range fetches
// PORTS
//   clock_i    in   1            system clock, all logic on rising edge
//   reset_ni   in   1            asynchronous reset, active low
//   enable_i   in   1            fetch-accept enable
//   i_read_i   in   1            fetch request from core, held until acked
//   i_rack_o   out  1            request accepted (combinational)
//   i_ready_o  out  1            one-cycle strobe, i_data_o valid
//   i_addr_i   in   ADDRESS      fetch word address
//   i_data_o   out  INSTRUCTION  fetched instruction
//   i_err_o    out  1            one-cycle strobe with i_ready_o, fetch was out of range
//   l_write_i  in   1            loader write request
//   l_wack_o   out  1            loader write accepted (combinational)
//   l_addr_i   in   DEPTHBITS    loader word address
//   l_data_i   in   INSTRUCTION  loader write data
// BEHAVIOUR
//   - Reset (asynchronous): state=IDLE, wait counter=0, i_ready_o=0, i_err_o=0, i_data_o=0.
//     RAM contents are not cleared.
//   - FSM with states IDLE and STALL; a down-counter holds the remaining wait states.
//   - Accept in IDLE: i_rack_o = i_read_i & enable_i & !l_write_i.
//     i_rack_o=0 in STALL. Address is latched on accept.
//   - Accept at cycle t, WAIT=0: RAM read issued at t; i_ready_o=1 with data at t+1; state stays IDLE.
//     Back-to-back accepts give one instruction per cycle.
//   - Accept at cycle t, WAIT=N>0: go to STALL with counter=N. Decrement each cycle.
//     The RAM read is issued on the cycle the counter reaches 0, then the state returns to IDLE.
//     i_ready_o asserts at t+N+1, the same cycle the next request may be accepted.
//     Throughput is one fetch per N+1 cycles.
//   - Range check: a fetch is out of range when i_addr_i[ADDRESS-1:DEPTHBITS] != 0.
//     The response keeps normal latency, with i_data_o=NOP and i_err_o=1. The RAM is not read.
//   - i_data_o holds its last value between strobes; i_ready_o and i_err_o are single-cycle pulses.
//   - Loader: l_wack_o = l_write_i & (state==IDLE). The write commits at that edge.
//     The loader has priority over a same-cycle fetch, which sees i_rack_o=0 and retries next cycle.
//     In STALL the write is held off: l_wack_o=0.
//   - Read-after-write: a fetch accepted the cycle after a loader write returns the new word.
//   - enable_i=0: no new accepts. Any in-flight fetch completes normally.
//   - Reset mid-fetch: the fetch is discarded and no i_ready_o is issued for it.
// TESTING
//   1 WAIT=0: load words 0..3 = 32'hA000_0000+i, then hold i_read_i high with addr 0,1,2,3 ->
//     i_rack_o every cycle; i_ready_o on the next 4 cycles; data A0000000..A0000003.
//   2 WAIT=2: accept addr 5 (word 32'h1234_5678) at t -> i_rack_o=0 at t+1,t+2;
//     i_ready_o and data 32'h12345678 at t+3; a second request is acked at t+3.
//   3 l_write_i (addr 7, data 32'hDEAD_BEEF) and i_read_i (addr 7) in the same IDLE cycle ->
//     l_wack_o=1, i_rack_o=0; next cycle i_rack_o=1; response is DEADBEEF.
//   4 Fetch addr 28'h000_0200 (DEPTHBITS=9) -> normal latency, i_data_o=NOP, i_err_o=1 for exactly 1 cycle.
//   5 WAIT=2, reset_ni low at t+1 after accept -> no i_ready_o; outputs 0;
//     after release a fetch of addr 0 returns A0000000 at normal latency.
//   6 enable_i=0 with i_read_i high for 5 cycles -> i_rack_o stays 0; raise enable_i -> acked the same cycle.

Source files
------------

// File: rtl/th_imem_responder.sv
// Memory-side responder for the TTA instruction-fetch bus, backed by a synchronous-read
// program store with a configurable number of wait states and a loader write port.
module th_imem_responder #(
    parameter int unsigned WIDTH              = 18,
    parameter int unsigned PAGEWIDTH          = 10,
    parameter int unsigned INSTRUCTION        = 32,
    parameter int unsigned DEPTHBITS          = 9,
    parameter int unsigned WAIT               = 0,
    parameter logic [INSTRUCTION-1:0] NOP     = '0
) (
    input  logic                         clock_i,
    input  logic                         reset_ni,
    input  logic                         enable_i,
    input  logic                         i_read_i,
    output logic                         i_rack_o,
    output logic                         i_ready_o,
    input  logic [WIDTH+PAGEWIDTH-1:0]   i_addr_i,
    output logic [INSTRUCTION-1:0]       i_data_o,
    output logic                         i_err_o,
    input  logic                         l_write_i,
    output logic                         l_wack_o,
    input  logic [DEPTHBITS-1:0]         l_addr_i,
    input  logic [INSTRUCTION-1:0]       l_data_i
);

    localparam int unsigned ADDRESS = WIDTH + PAGEWIDTH;
    localparam int unsigned DEPTH   = 1 << DEPTHBITS;
    localparam int unsigned CNTW    = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic [DEPTHBITS-1:0]   idx_q;
    logic                   oob_q;

    logic                   fire_c;
    logic                   addr_oob_c;
    logic [DEPTHBITS-1:0]   sel_idx_c;
    logic                   sel_oob_c;

    logic [INSTRUCTION-1:0] mem [DEPTH];

    // Any nonzero bit above the store's index field makes the fetch out of range.
    assign addr_oob_c = |i_addr_i[ADDRESS-1:DEPTHBITS];

    // With no wait states the read uses the live address; after a stall it uses the latched one.
    assign sel_idx_c = (state_q == IDLE) ? i_addr_i[DEPTHBITS-1:0] : idx_q;
    assign sel_oob_c = (state_q == IDLE) ? addr_oob_c : oob_q;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Accept/handshake decode, wait-state countdown and read-issue timing.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fire_c   = 1'b0;
        i_rack_o = 1'b0;
        l_wack_o = 1'b0;
        case (state_q)
            IDLE: begin
                l_wack_o = l_write_i;
                i_rack_o = i_read_i & enable_i & ~l_write_i;
                if (i_rack_o) begin
                    if (WAIT == 0) begin
                        fire_c = 1'b1;
                    end else begin
                        state_d = STALL;
                        cnt_d   = CNTW'(WAIT);
                    end
                end
            end
            STALL: begin
                if (cnt_q <= CNTW'(1)) begin
                    fire_c  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Program store write port; contents survive reset.
    always_ff @(posedge clock_i) begin
        if (l_wack_o) begin
            mem[l_addr_i] <= l_data_i;
        end
    end

    // Address latch and registered response; the store is only read for in-range fetches.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            i_ready_o <= 1'b0;
            i_err_o   <= 1'b0;
            i_data_o  <= '0;
            idx_q     <= '0;
            oob_q     <= 1'b0;
        end else begin
            i_ready_o <= fire_c;
            i_err_o   <= fire_c & sel_oob_c;
            if (i_rack_o) begin
                idx_q <= i_addr_i[DEPTHBITS-1:0];
                oob_q <= addr_oob_c;
            end
            if (fire_c) begin
                i_data_o <= sel_oob_c ? NOP : mem[sel_idx_c];
            end
        end
    end

endmodule

// File: tb/tb_th_imem_responder.sv
// Bench for th_imem_responder: a zero-wait and a two-wait instance share one stimulus stream
// and are checked every cycle against a cycle-count model plus hand-computed expectations.
module tb_th_imem_responder;

    localparam logic [31:0] NOPW = 32'hC0DE_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        i_read;
    logic [27:0] i_addr;
    logic        l_write;
    logic [8:0]  l_addr;
    logic [31:0] l_data;

    logic        rack_0, ready_0, err_0, wack_0;
    logic [31:0] data_0;
    logic        rack_2, ready_2, err_2, wack_2;
    logic [31:0] data_2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    th_imem_responder #(.WAIT(0), .NOP(NOPW)) dut0 (
        .clock_i(clock), .reset_ni(reset_n), .enable_i(enable),
        .i_read_i(i_read), .i_rack_o(rack_0), .i_ready_o(ready_0),
        .i_addr_i(i_addr), .i_data_o(data_0), .i_err_o(err_0),
        .l_write_i(l_write), .l_wack_o(wack_0), .l_addr_i(l_addr), .l_data_i(l_data)
    );

    th_imem_responder #(.WAIT(2), .NOP(NOPW)) dut2 (
        .clock_i(clock), .reset_ni(reset_n), .enable_i(enable),
        .i_read_i(i_read), .i_rack_o(rack_2), .i_ready_o(ready_2),
        .i_addr_i(i_addr), .i_data_o(data_2), .i_err_o(err_2),
        .l_write_i(l_write), .l_wack_o(wack_2), .l_addr_i(l_addr), .l_data_i(l_data)
    );

    logic        rack_v  [2];
    logic        wack_v  [2];
    logic        ready_v [2];
    logic        err_v   [2];
    logic [31:0] data_v  [2];
    assign rack_v[0]  = rack_0;  assign rack_v[1]  = rack_2;
    assign wack_v[0]  = wack_0;  assign wack_v[1]  = wack_2;
    assign ready_v[0] = ready_0; assign ready_v[1] = ready_2;
    assign err_v[0]   = err_0;   assign err_v[1]   = err_2;
    assign data_v[0]  = data_0;  assign data_v[1]  = data_2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a fetch accepted at cycle c answers at c+W+1 and the port is busy until then.
    int          cyc = 0;
    int          waits   [2] = '{0, 2};
    int          free_at [2] = '{0, 0};
    int          resp_at [2] = '{0, 0};
    bit          resp_pend [2] = '{0, 0};
    logic [31:0] resp_data [2];
    bit          resp_err  [2];
    logic [31:0] last_data [2] = '{32'h0, 32'h0};
    logic [31:0] mm [2][512];

    always @(negedge clock) begin : cmp
        bit idle, e_wack, e_rack, e_ready, oob;
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                resp_pend[k] = 1'b0;
                last_data[k] = 32'h0;
                free_at[k]   = cyc + 1;
                chk($sformatf("rst_ready%0d", k), 32'(ready_v[k]), 32'h0);
                chk($sformatf("rst_err%0d", k), 32'(err_v[k]), 32'h0);
                chk($sformatf("rst_data%0d", k), data_v[k], 32'h0);
            end else begin
                idle    = (cyc >= free_at[k]);
                e_wack  = l_write & idle;
                e_rack  = idle & i_read & enable & ~l_write;
                e_ready = resp_pend[k] && (resp_at[k] == cyc);
                if (e_ready) begin
                    last_data[k] = resp_data[k];
                    resp_pend[k] = 1'b0;
                end
                chk($sformatf("m_rack%0d", k), 32'(rack_v[k]), 32'(e_rack));
                chk($sformatf("m_wack%0d", k), 32'(wack_v[k]), 32'(e_wack));
                chk($sformatf("m_ready%0d", k), 32'(ready_v[k]), 32'(e_ready));
                chk($sformatf("m_err%0d", k), 32'(err_v[k]), 32'(e_ready & resp_err[k]));
                chk($sformatf("m_data%0d", k), data_v[k], last_data[k]);
                if (e_wack) mm[k][l_addr] = l_data;
                if (e_rack) begin
                    oob          = (i_addr >= 28'd512);
                    resp_err[k]  = oob;
                    resp_data[k] = oob ? NOPW : mm[k][i_addr % 512];
                    resp_pend[k] = 1'b1;
                    resp_at[k]   = cyc + waits[k] + 1;
                    free_at[k]   = cyc + waits[k] + 1;
                end
            end
        end
        cyc++;
    end

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic samp();
        @(negedge clock);
    endtask

    task automatic load(input logic [8:0] a, input logic [31:0] d);
        l_write = 1'b1;
        l_addr  = a;
        l_data  = d;
        nxt();
        l_write = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        i_read  = 1'b0;
        i_addr  = '0;
        l_write = 1'b0;
        l_addr  = '0;
        l_data  = '0;
        nxt();
        nxt();
        reset_n = 1'b1;
        nxt();

        for (int i = 0; i < 4; i++) load(9'(i), 32'hA000_0000 + 32'(i));
        load(9'd5, 32'h1234_5678);
        load(9'd1, 32'hA000_0001);

        // 1: zero-wait back-to-back fetches
        i_read = 1'b1;
        i_addr = 28'd0;
        samp();
        chk("t1_rack0", 32'(rack_0), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            nxt();
            if (i < 4) i_addr = 28'(i);
            else       i_read = 1'b0;
            samp();
            if (i < 4) chk("t1_rack0", 32'(rack_0), 32'h1);
            chk("t1_ready0", 32'(ready_0), 32'h1);
            chk("t1_data0", data_0, 32'hA000_0000 + 32'(i - 1));
        end
        repeat (4) nxt();

        // 2: two wait states
        i_read = 1'b1;
        i_addr = 28'd5;
        samp();
        chk("t2_rack2_t", 32'(rack_2), 32'h1);
        nxt(); samp();
        chk("t2_rack2_t1", 32'(rack_2), 32'h0);
        chk("t2_ready2_t1", 32'(ready_2), 32'h0);
        nxt(); samp();
        chk("t2_rack2_t2", 32'(rack_2), 32'h0);
        nxt(); samp();
        chk("t2_ready2_t3", 32'(ready_2), 32'h1);
        chk("t2_data2_t3", data_2, 32'h1234_5678);
        chk("t2_rack2_t3", 32'(rack_2), 32'h1);
        nxt();
        i_read = 1'b0;
        repeat (4) nxt();

        // 3: loader wins a same-cycle collision, then read-after-write
        l_write = 1'b1;
        l_addr  = 9'd7;
        l_data  = 32'hDEAD_BEEF;
        i_read  = 1'b1;
        i_addr  = 28'd7;
        samp();
        chk("t3_wack0", 32'(wack_0), 32'h1);
        chk("t3_rack0", 32'(rack_0), 32'h0);
        chk("t3_wack2", 32'(wack_2), 32'h1);
        chk("t3_rack2", 32'(rack_2), 32'h0);
        nxt();
        l_write = 1'b0;
        samp();
        chk("t3_rack0_retry", 32'(rack_0), 32'h1);
        chk("t3_rack2_retry", 32'(rack_2), 32'h1);
        nxt();
        i_read = 1'b0;
        samp();
        chk("t3_ready0", 32'(ready_0), 32'h1);
        chk("t3_data0", data_0, 32'hDEAD_BEEF);
        nxt(); nxt(); samp();
        chk("t3_ready2", 32'(ready_2), 32'h1);
        chk("t3_data2", data_2, 32'hDEAD_BEEF);

        // 4: out-of-range fetch
        nxt();
        i_read = 1'b1;
        i_addr = 28'h000_0200;
        samp();
        chk("t4_rack0", 32'(rack_0), 32'h1);
        nxt();
        i_read = 1'b0;
        samp();
        chk("t4_ready0", 32'(ready_0), 32'h1);
        chk("t4_err0", 32'(err_0), 32'h1);
        chk("t4_data0", data_0, NOPW);
        nxt(); samp();
        chk("t4_err0_drop", 32'(err_0), 32'h0);
        chk("t4_data0_hold", data_0, NOPW);
        nxt(); samp();
        chk("t4_err2", 32'(err_2), 32'h1);
        chk("t4_data2", data_2, NOPW);
        nxt(); samp();
        chk("t4_err2_drop", 32'(err_2), 32'h0);

        // 5: reset in the middle of a stalled fetch
        nxt();
        i_read = 1'b1;
        i_addr = 28'd0;
        samp();
        chk("t5_rack2", 32'(rack_2), 32'h1);
        nxt();
        i_read  = 1'b0;
        reset_n = 1'b0;
        samp();
        chk("t5_ready2_rst", 32'(ready_2), 32'h0);
        chk("t5_data2_rst", data_2, 32'h0);
        nxt();
        nxt();
        reset_n = 1'b1;
        samp();
        chk("t5_ready2_late", 32'(ready_2), 32'h0);
        nxt(); samp();
        chk("t5_ready2_none", 32'(ready_2), 32'h0);
        nxt();
        i_read = 1'b1;
        i_addr = 28'd0;
        samp();
        chk("t5_rack2_post", 32'(rack_2), 32'h1);
        nxt();
        i_read = 1'b0;
        samp();
        chk("t5_data0_post", data_0, 32'hA000_0000);
        nxt(); nxt(); samp();
        chk("t5_ready2_post", 32'(ready_2), 32'h1);
        chk("t5_data2_post", data_2, 32'hA000_0000);

        // 6: enable gating
        nxt();
        enable = 1'b0;
        i_read = 1'b1;
        i_addr = 28'd1;
        for (int i = 0; i < 5; i++) begin
            samp();
            chk("t6_rack0_off", 32'(rack_0), 32'h0);
            chk("t6_rack2_off", 32'(rack_2), 32'h0);
            nxt();
        end
        enable = 1'b1;
        samp();
        chk("t6_rack0_on", 32'(rack_0), 32'h1);
        chk("t6_rack2_on", 32'(rack_2), 32'h1);
        nxt();
        i_read = 1'b0;
        samp();
        chk("t6_data0", data_0, 32'hA000_0001);
        repeat (5) nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
